mdio_mgmt_master: RTL

MDIO_MGMT_MASTER -- requirements
Module: mdio_mgmt_master

---
 rtl/mdio_pkg.sv | 41 ++++
 rtl/mdio_mgmt_master.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared states, frame codes and bit counts for the MDIO master
package mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE
    } mdio_state_e;

    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] ST    = 2'b01;

    localparam int PRE_BITS  = 32;
    localparam int HDR_BITS  = 14;
    localparam int TA_BITS   = 2;
    localparam int DATA_BITS = 16;

    function automatic logic [4:0] last_bit(input mdio_state_e s);
        case (s)
            S_PRE:   last_bit = 5'(PRE_BITS - 1);
            S_HDR:   last_bit = 5'(HDR_BITS - 1);
            S_TA:    last_bit = 5'(TA_BITS - 1);
            S_DATA:  last_bit = 5'(DATA_BITS - 1);
            default: last_bit = 5'd0;
        endcase
    endfunction

    function automatic mdio_state_e next_phase(input mdio_state_e s);
        case (s)
            S_PRE:   next_phase = S_HDR;
            S_HDR:   next_phase = S_TA;
            S_TA:    next_phase = S_DATA;
            default: next_phase = S_DONE;
        endcase
    endfunction

endpackage

// File: rtl/mdio_mgmt_master.sv
// rtl/mdio_mgmt_master.sv - Clause 22 MDIO management master with MDC divider and read sampler
module mdio_mgmt_master
    import mdio_pkg::*;
#(
    parameter int MdcHalfDiv = 10,
    parameter bit PreambleEn = 1'b1
) (
    input  logic        board_clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [4:0]  req_phy_i,
    input  logic [4:0]  req_reg_i,
    input  logic [15:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i
);

    localparam logic [7:0] DIV_LAST = 8'(MdcHalfDiv - 1);

    mdio_state_e state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  div_q;
    logic [31:0] frame_q, frame_d;
    logic        write_q, err_q, ready_q;
    logic [15:0] rx_sr_q, rdata_q;
    logic        sync1_q, sync2_q;
    logic        mdio_d, mdio_oe_d;
    logic        accept, div_wrap, mdc_fall, sample_en;

    assign accept      = req_valid_i & ready_q;
    assign div_wrap    = (div_q == DIV_LAST);
    assign mdc_fall    = div_wrap & mdc_o;
    // Two cycles after the rise, sync2 holds the pad value from just before the rise.
    assign sample_en   = mdc_o & (div_q == 8'd1) & ~write_q;

    assign req_ready_o = ready_q;
    assign rsp_valid_o = (state_q == S_DONE) & div_wrap;
    assign rsp_err_o   = rsp_valid_o & err_q & ~write_q;
    assign rsp_rdata_o = rdata_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        mdio_d    = 1'b1;
        mdio_oe_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = PreambleEn ? S_PRE : S_HDR;
                    bit_cnt_d = '0;
                    frame_d   = {ST, (req_write_i ? OP_WR : OP_RD), req_phy_i, req_reg_i,
                                 2'b10, req_wdata_i};
                end
            end
            S_PRE, S_HDR, S_TA, S_DATA: begin
                if (mdc_fall) begin
                    if (bit_cnt_q == last_bit(state_q)) begin
                        state_d   = next_phase(state_q);
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_DONE: begin
                if (div_wrap) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Drive value for whichever bit is current after this edge.
        case (state_d)
            S_PRE: mdio_oe_d = 1'b1;
            S_HDR: begin
                mdio_d    = frame_d[5'd31 - bit_cnt_d];
                mdio_oe_d = 1'b1;
            end
            S_TA: begin
                mdio_d    = write_q ? frame_d[5'd17 - bit_cnt_d] : 1'b1;
                mdio_oe_d = write_q;
            end
            S_DATA: begin
                mdio_d    = write_q ? frame_d[5'd15 - bit_cnt_d] : 1'b1;
                mdio_oe_d = write_q;
            end
            default: begin
                mdio_d    = 1'b1;
                mdio_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge board_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            write_q   <= 1'b0;
            ready_q   <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_oe_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            ready_q   <= (state_d == S_IDLE);
            mdio_o    <= mdio_d;
            mdio_oe_o <= mdio_oe_d;
            if (accept) write_q <= req_write_i;
        end
    end

    always_ff @(posedge board_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            mdc_o <= 1'b0;
        end else if (state_q == S_IDLE) begin
            div_q <= '0;
            mdc_o <= 1'b0;
        end else begin
            div_q <= div_wrap ? '0 : div_q + 8'd1;
            mdc_o <= (state_d == S_DONE || state_d == S_IDLE) ? 1'b0 :
                     (div_wrap ? ~mdc_o : mdc_o);
        end
    end

    always_ff @(posedge board_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            rx_sr_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            sync1_q <= mdio_i;
            sync2_q <= sync1_q;
            if (accept) err_q <= 1'b0;
            if (sample_en && state_q == S_TA && bit_cnt_q == 5'd1) err_q <= sync2_q;
            if (sample_en && state_q == S_DATA) rx_sr_q <= {rx_sr_q[14:0], sync2_q};
            if (state_q == S_DONE && div_q == 8'd0 && !write_q) rdata_q <= rx_sr_q;
        end
    end

endmodule
